// File: rtl/ray_scan_scheduler_if.sv
// Handshake bundle between the frame-scan scheduler, the
// frame/VGA control logic, the ray tracer and the frame buffer.
interface ray_scan_scheduler_if;
    logic        frame_req;
    logic        busy;
    logic        frame_done;
    logic        trace_start;
    logic [6:0]  trace_col;
    logic [5:0]  trace_row;
    logic        trace_done;
    logic [11:0] trace_color;
    logic        trace_hit;
    logic        fb_we;
    logic [6:0]  fb_col;
    logic [5:0]  fb_row;
    logic [11:0] fb_data;
    logic [3:0]  collision_sig;
    logic        timeout_err;

    modport master (
        input  frame_req, trace_done, trace_color, trace_hit,
        output busy, frame_done, trace_start, trace_col, trace_row,
        output fb_we, fb_col, fb_row, fb_data,
        output collision_sig, timeout_err
    );

    modport slave (
        output frame_req, trace_done, trace_color, trace_hit,
        input  busy, frame_done, trace_start, trace_col, trace_row,
        input  fb_we, fb_col, fb_row, fb_data,
        input  collision_sig, timeout_err
    );
endinterface

// File: rtl/ray_scan_scheduler.sv
// Raster-order pixel scheduler for the ray tracer: one trace per
// pixel, watchdog on the tracer, per-frame collision summary.
module ray_scan_scheduler #(
    parameter int          COLS          = 128,
    parameter int          ROWS          = 64,
    parameter int          TIMEOUT       = 1023,
    parameter logic [11:0] TIMEOUT_COLOR = 12'hF0F
) (
    input logic               tracer_clk,
    input logic               rst,
    ray_scan_scheduler_if.master bus
);
    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);
    localparam logic [9:0] WD_LAST  = 10'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t     state;
    logic [9:0] wd;
    logic [3:0] coll_work;
    logic [3:0] hit_flags;
    logic       last_pix;

    assign last_pix = (bus.trace_col == COL_LAST) &&
                      (bus.trace_row == ROW_LAST);

    // Collision bits {left, right, front, back} for the pixel in flight.
    always_comb begin
        hit_flags = '0;
        if (bus.trace_hit) begin
            hit_flags = {bus.trace_col == 7'd0,
                         bus.trace_col == COL_LAST,
                         1'b1,
                         bus.trace_row == ROW_LAST};
        end
    end

    // Scan FSM; the coordinate lives directly in trace_col/trace_row.
    always_ff @(posedge tracer_clk) begin
        if (rst) begin
            state             <= IDLE;
            wd                <= '0;
            coll_work         <= '0;
            bus.busy          <= 1'b0;
            bus.frame_done    <= 1'b0;
            bus.trace_start   <= 1'b0;
            bus.trace_col     <= '0;
            bus.trace_row     <= '0;
            bus.fb_we         <= 1'b0;
            bus.fb_col        <= '0;
            bus.fb_row        <= '0;
            bus.fb_data       <= '0;
            bus.collision_sig <= '0;
            bus.timeout_err   <= 1'b0;
        end else begin
            bus.trace_start <= 1'b0;
            bus.fb_we       <= 1'b0;
            bus.frame_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.frame_req) begin
                        bus.trace_col   <= '0;
                        bus.trace_row   <= '0;
                        coll_work       <= '0;
                        bus.timeout_err <= 1'b0;
                        bus.trace_start <= 1'b1;
                        bus.busy        <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wd <= wd + 10'd1;
                    if (bus.trace_done) begin
                        bus.fb_data <= bus.trace_color;
                        coll_work   <= coll_work | hit_flags;
                        bus.fb_we   <= 1'b1;
                        bus.fb_col  <= bus.trace_col;
                        bus.fb_row  <= bus.trace_row;
                        state       <= WRITE;
                    end else if (wd == WD_LAST) begin
                        bus.fb_data     <= TIMEOUT_COLOR;
                        bus.timeout_err <= 1'b1;
                        bus.fb_we       <= 1'b1;
                        bus.fb_col      <= bus.trace_col;
                        bus.fb_row      <= bus.trace_row;
                        state           <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_pix) begin
                        state <= DONE;
                    end else begin
                        if (bus.trace_col == COL_LAST) begin
                            bus.trace_col <= '0;
                            bus.trace_row <= bus.trace_row + 6'd1;
                        end else begin
                            bus.trace_col <= bus.trace_col + 7'd1;
                        end
                        bus.trace_start <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                DONE: begin
                    bus.frame_done    <= 1'b1;
                    bus.collision_sig <= coll_work;
                    bus.busy          <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ray_scan_scheduler.sv
// Randomised bench for ray_scan_scheduler: a cycle-level model of
// pixel/frame timing predicts every output on every cycle.
module tb_ray_scan_scheduler;
    localparam int          COLS     = 4;
    localparam int          ROWS     = 2;
    localparam int          TIMEOUT  = 8;
    localparam int          NPIX     = COLS * ROWS;
    localparam logic [11:0] TO_COLOR = 12'hF0F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle counter used by the model and the pinned latencies.
    always @(posedge clk) cyc <= cyc + 1;

    ray_scan_scheduler_if bus_if ();

    ray_scan_scheduler #(
        .COLS          (COLS),
        .ROWS          (ROWS),
        .TIMEOUT       (TIMEOUT),
        .TIMEOUT_COLOR (TO_COLOR)
    ) dut (
        .tracer_clk (clk),
        .rst        (rst),
        .bus        (bus_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-frame tracer behaviour: WAIT cycle of the response,
    // colour, hit, and a stray done pulse during ISSUE.
    int          plan_k     [NPIX];
    logic [11:0] plan_color [NPIX];
    bit          plan_hit   [NPIX];
    bit          plan_spur  [NPIX];

    int spur_req = 0;
    int spur_ack = 0;

    // Tracer stand-in: answers each trace_start per the plan.
    initial begin
        bus_if.trace_done  = 1'b0;
        bus_if.trace_color = '0;
        bus_if.trace_hit   = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.trace_start) begin
                int p;
                int k;
                p = int'(bus_if.trace_row) * COLS + int'(bus_if.trace_col);
                if (p >= NPIX) p = 0;
                k = plan_k[p];
                bus_if.trace_done = plan_spur[p];
                bus_if.trace_color = 12'($urandom);
                bus_if.trace_hit = 1'b1;
                @(posedge clk);
                #1 bus_if.trace_done = 1'b0;
                for (int j = 1; j < k; j++) begin
                    @(posedge clk);
                    #1;
                end
                bus_if.trace_color = plan_color[p];
                bus_if.trace_hit   = plan_hit[p];
                bus_if.trace_done  = 1'b1;
                @(posedge clk);
                #1 bus_if.trace_done = 1'b0;
                bus_if.trace_color = 12'($urandom);
                bus_if.trace_hit   = 1'($urandom);
            end else if (spur_req != spur_ack) begin
                bus_if.trace_done  = 1'b1;
                bus_if.trace_color = 12'($urandom);
                bus_if.trace_hit   = 1'b1;
                @(posedge clk);
                #1 bus_if.trace_done = 1'b0;
                spur_ack++;
            end
        end
    end

    // Model state: expected event cycles of the frame in progress.
    bit          m_active     = 1'b0;
    int          m_next_start = -1;
    int          exp_wr       = -1;
    int          exp_done     = -1;
    int          m_idx        = 0;
    int          wr_col       = 0;
    int          wr_row       = 0;
    logic [11:0] wr_data      = '0;
    bit          wr_hit       = 1'b0;
    bit          wr_to        = 1'b0;
    logic [3:0]  m_coll       = '0;
    logic [3:0]  m_sig        = '0;
    bit          m_to         = 1'b0;
    int          m_first      = -1;
    int          start_cyc    = 0;
    int          to_lat       = -1;
    int          m_writes     = 0;

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        if (m_active && cyc == exp_done) begin
            m_active = 1'b0;
            m_sig    = m_coll;
        end
        chk("trace_start", bus_if.trace_start, cyc == m_next_start);
        if (cyc == m_next_start) begin
            wr_col = m_idx % COLS;
            wr_row = m_idx / COLS;
            chk("trace_col", bus_if.trace_col, wr_col);
            chk("trace_row", bus_if.trace_row, wr_row);
            if (m_idx == 0) m_first = cyc;
            start_cyc = cyc;
            if (plan_k[m_idx] <= TIMEOUT) begin
                exp_wr  = cyc + plan_k[m_idx] + 1;
                wr_data = plan_color[m_idx];
                wr_hit  = plan_hit[m_idx];
                wr_to   = 1'b0;
            end else begin
                exp_wr  = cyc + TIMEOUT + 1;
                wr_data = TO_COLOR;
                wr_hit  = 1'b0;
                wr_to   = 1'b1;
            end
        end
        chk("fb_we", bus_if.fb_we, cyc == exp_wr);
        if (cyc == exp_wr) begin
            chk("fb_col", bus_if.fb_col, wr_col);
            chk("fb_row", bus_if.fb_row, wr_row);
            chk("fb_data", bus_if.fb_data, wr_data);
            if (wr_hit) begin
                m_coll = m_coll | {wr_col == 0, wr_col == COLS - 1,
                                   1'b1, wr_row == ROWS - 1};
            end
            if (wr_to) begin
                m_to   = 1'b1;
                to_lat = cyc - start_cyc;
            end
            m_writes++;
            m_idx++;
            if (m_idx == NPIX) exp_done = cyc + 2;
            else m_next_start = cyc + 1;
        end
        chk("frame_done", bus_if.frame_done, cyc == exp_done);
        chk("busy", bus_if.busy, m_active);
        chk("collision_sig", bus_if.collision_sig, m_sig);
        chk("timeout_err", bus_if.timeout_err, m_to);
        if (rst) begin
            m_active     = 1'b0;
            m_next_start = -1;
            exp_wr       = -1;
            exp_done     = -1;
            m_coll       = '0;
            m_sig        = '0;
            m_to         = 1'b0;
        end else if (!m_active && bus_if.frame_req) begin
            m_active     = 1'b1;
            m_next_start = cyc + 1;
            exp_wr       = -1;
            exp_done     = -1;
            m_idx        = 0;
            m_coll       = '0;
            m_to         = 1'b0;
            m_writes     = 0;
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, bus_if.busy, 0);
        chk({tag, "_frame_done"}, bus_if.frame_done, 0);
        chk({tag, "_trace_start"}, bus_if.trace_start, 0);
        chk({tag, "_trace_col"}, bus_if.trace_col, 0);
        chk({tag, "_trace_row"}, bus_if.trace_row, 0);
        chk({tag, "_fb_we"}, bus_if.fb_we, 0);
        chk({tag, "_fb_col"}, bus_if.fb_col, 0);
        chk({tag, "_fb_row"}, bus_if.fb_row, 0);
        chk({tag, "_fb_data"}, bus_if.fb_data, 0);
        chk({tag, "_collision_sig"}, bus_if.collision_sig, 0);
        chk({tag, "_timeout_err"}, bus_if.timeout_err, 0);
    endtask

    task automatic plain_plan();
        for (int i = 0; i < NPIX; i++) begin
            plan_k[i]     = 1;
            plan_color[i] = {6'(i / COLS), 6'(i % COLS)};
            plan_hit[i]   = 1'b0;
            plan_spur[i]  = 1'b0;
        end
    endtask

    task automatic rand_plan();
        int r;
        for (int i = 0; i < NPIX; i++) begin
            r = $urandom_range(0, 9);
            plan_k[i] = $urandom_range(1, 4);
            if (r == 0) plan_k[i] = TIMEOUT + 1;
            if (r == 1) plan_k[i] = TIMEOUT;
            plan_color[i] = 12'($urandom);
            plan_hit[i]   = 1'($urandom_range(0, 1));
            plan_spur[i]  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_done(output int dc);
        bit found = 1'b0;
        dc = -1;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            if (bus_if.frame_done) begin
                found = 1'b1;
                dc    = cyc;
            end
        end
        chk("frame_done_seen", found, 1'b1);
    endtask

    // Idle done pulse, accept, stray request while busy, wait.
    task automatic run_frame(output int dc);
        spur_req++;
        repeat (3) @(posedge clk);
        #1 bus_if.frame_req = 1'b1;
        @(posedge clk);
        #1 bus_if.frame_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus_if.frame_req = 1'b1;
        @(posedge clk);
        #1 bus_if.frame_req = 1'b0;
        wait_done(dc);
    endtask

    initial begin
        int  dc;
        int  d1;
        bit  found;
        bus_if.frame_req = 1'b0;
        plain_plan();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        plain_plan();
        run_frame(dc);
        chk("f1_latency", dc - m_first, 25);
        chk("f1_writes", m_writes, 8);
        chk("f1_coll", bus_if.collision_sig, 4'b0000);

        plain_plan();
        plan_hit[0] = 1'b1;
        plan_hit[7] = 1'b1;
        run_frame(dc);
        chk("f2_coll", bus_if.collision_sig, 4'b1111);

        plain_plan();
        plan_hit[1] = 1'b1;
        run_frame(dc);
        chk("f3_coll", bus_if.collision_sig, 4'b0010);

        rand_plan();
        plan_k[2] = TIMEOUT + 1;
        run_frame(dc);
        chk("wd_latency", to_lat, 9);
        chk("wd_err", bus_if.timeout_err, 1'b1);
        chk("wd_writes", m_writes, 8);

        plain_plan();
        plan_k[1]     = TIMEOUT;
        plan_color[1] = 12'hABC;
        plan_spur[3]  = 1'b1;
        run_frame(dc);
        chk("tie_err", bus_if.timeout_err, 1'b0);

        rand_plan();
        @(posedge clk);
        #1 bus_if.frame_req = 1'b1;
        wait_done(d1);
        @(posedge clk);
        #1 bus_if.frame_req = 1'b0;
        wait_done(dc);
        chk("b2b_gap", m_first - d1, 1);

        for (int f = 0; f < 8; f++) begin
            rand_plan();
            run_frame(dc);
        end

        plain_plan();
        plan_k[5] = 6;
        @(posedge clk);
        #1 bus_if.frame_req = 1'b1;
        @(posedge clk);
        #1 bus_if.frame_req = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (bus_if.trace_start && bus_if.trace_col == 7'd1 &&
                bus_if.trace_row == 6'd1) found = 1'b1;
        end
        chk("mid_reset_reach", found, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("mid_reset");
        repeat (10) @(posedge clk);

        rand_plan();
        run_frame(dc);
        chk("restart_writes", m_writes, 8);

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
